// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// ----------------------------------------------------------------------------
// Multicycle control unit for the 8-bit mini-MIPS datapath. Each 32-bit
// instruction is fetched one byte per cycle (FETCH1..FETCH<IRBYTES>). It is then
// decoded and walked through execute, memory and writeback states. The unit
// drives every datapath mux select and write enable, plus the 3-bit ALU
// control word.
//
// Parameters:
//   IRBYTES   instruction-register byte beats per fetch (1..4, default 4)
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   reset     synchronous, active-high; write enables are forced low while high
//   op        instr[31:26] from the instruction register
//   funct     instr[5:0] from the instruction register
//   zero      ALU result == 0 flag (only matters for beq)
//   memread   memory read strobe
//   memwrite  memory write strobe
//   iord      memory address mux: 0 = PC, 1 = ALU out
//   memtoreg  register write data: 0 = ALU out, 1 = memory data
//   regwrite  register file write enable
//   regdst    destination register: 0 = rt, 1 = rd
//   alusrca   ALU a: 0 = PC, 1 = rs
//   alusrcb   ALU b: 00 rt, 01 constant 1, 10 imm, 11 imm (branch offset)
//   pcsource  next PC: 00 ALU result, 01 ALU out register, 10 jump target
//   pcen      PC write enable = pcwrite | (branch & zero)
//   irwrite   one-hot byte load of the instruction register
//   alucont   ALU control: bit 2 invert b / carry in, bits 1:0 AND/OR/add/slt
//   halt      illegal-opcode halt flag
//
// Optional feature macro: MIPS_CTRL_ILLEGAL_HALT_EN
//   Defined   : an unknown opcode parks the FSM in HALT (halt = 1) until reset.
//   Undefined : an unknown opcode goes straight back to FETCH1; halt is 0.
// ----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int IRBYTES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               memread,
    output logic               memwrite,
    output logic               iord,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               regdst,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsource,
    output logic               pcen,
    output logic [IRBYTES-1:0] irwrite,
    output logic [2:0]         alucont,
    output logic               halt
);

    // Fetch states occupy encodings 0..3 so the low two bits give the byte
    // index directly. HALT takes the last encoding; without the halt feature
    // it is simply an unused encoding.
    typedef enum logic [3:0] {
        S_FETCH1  = 4'd0,
        S_FETCH2  = 4'd1,
        S_FETCH3  = 4'd2,
        S_FETCH4  = 4'd3,
        S_DECODE  = 4'd4,
        S_MEMADR  = 4'd5,
        S_LBRD    = 4'd6,
        S_LBWR    = 4'd7,
        S_SBWR    = 4'd8,
        S_RTYPEEX = 4'd9,
        S_RTYPEWR = 4'd10,
        S_BEQEX   = 4'd11,
        S_JEX     = 4'd12,
        S_ADDIEX  = 4'd13,
        S_ADDIWR  = 4'd14,
        S_HALT    = 4'd15
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Fetch encodings at or beyond IRBYTES are unused and are masked out here
    // so they fall into the "unused encoding" recovery path.
    localparam logic [3:0] FETCH_MASK = 4'((1 << IRBYTES) - 1);
    localparam logic [1:0] LAST_FETCH = 2'(IRBYTES - 1);

    state_e             state_q;
    state_e             state_d;
    logic [1:0]         fetch_idx;
    logic               in_fetch;
    logic               pcwrite;
    logic               branch;
    logic [1:0]         aluop;
    logic               regwrite_raw;
    logic               memwrite_raw;
    logic [IRBYTES-1:0] irwrite_raw;
    logic               halt_raw;

    assign fetch_idx = state_q[1:0];
    assign in_fetch  = (state_q[3:2] == 2'b00) && FETCH_MASK[fetch_idx];

    // State register. Reset abandons whatever instruction was in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Anything not explicitly handled, including unused
    // encodings, returns to FETCH1.
    always_comb begin
        state_d = S_FETCH1;
        if (in_fetch) begin
            if (fetch_idx == LAST_FETCH) begin
                state_d = S_DECODE;
            end else begin
                state_d = state_e'(state_q + 4'd1);
            end
        end else begin
            case (state_q)
                S_DECODE: begin
                    case (op)
                        OP_LB, OP_SB: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_RTYPEEX;
                        OP_BEQ:       state_d = S_BEQEX;
                        OP_J:         state_d = S_JEX;
                        OP_ADDI:      state_d = S_ADDIEX;
`ifdef MIPS_CTRL_ILLEGAL_HALT_EN
                        default:      state_d = S_HALT;
`else
                        default:      state_d = S_FETCH1;
`endif
                    endcase
                end
                S_MEMADR:  state_d = (op == OP_LB) ? S_LBRD : S_SBWR;
                S_LBRD:    state_d = S_LBWR;
                S_RTYPEEX: state_d = S_RTYPEWR;
                S_ADDIEX:  state_d = S_ADDIWR;
`ifdef MIPS_CTRL_ILLEGAL_HALT_EN
                S_HALT:    state_d = S_HALT;
`endif
                default:   state_d = S_FETCH1;
            endcase
        end
    end

    // Moore outputs decoded from the current state. Unused encodings (and
    // HALT) leave every enable low.
    always_comb begin
        memread      = 1'b0;
        memwrite_raw = 1'b0;
        iord         = 1'b0;
        memtoreg     = 1'b0;
        regwrite_raw = 1'b0;
        regdst       = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsource     = 2'b00;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        irwrite_raw  = '0;
        aluop        = ALUOP_ADD;
        halt_raw     = 1'b0;
        if (in_fetch) begin
            // PC + 1 while loading the next instruction byte.
            memread     = 1'b1;
            alusrcb     = 2'b01;
            pcwrite     = 1'b1;
            irwrite_raw = IRBYTES'(1) << fetch_idx;
        end else begin
            case (state_q)
                S_DECODE: alusrcb = 2'b11;
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_LBRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                S_LBWR: begin
                    regwrite_raw = 1'b1;
                    memtoreg     = 1'b1;
                end
                S_SBWR: begin
                    memwrite_raw = 1'b1;
                    iord         = 1'b1;
                end
                S_RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_FUNCT;
                end
                S_RTYPEWR: begin
                    regwrite_raw = 1'b1;
                    regdst       = 1'b1;
                end
                S_BEQEX: begin
                    alusrca  = 1'b1;
                    aluop    = ALUOP_SUB;
                    branch   = 1'b1;
                    pcsource = 2'b01;
                end
                S_JEX: begin
                    pcwrite  = 1'b1;
                    pcsource = 2'b10;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_ADDIWR: regwrite_raw = 1'b1;
`ifdef MIPS_CTRL_ILLEGAL_HALT_EN
                S_HALT:   halt_raw = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // ALU control word: fixed add/sub for address and branch math, funct
    // field decode for R-type. Unknown functs default to add.
    always_comb begin
        alucont = 3'b010;
        case (aluop)
            ALUOP_SUB: alucont = 3'b110;
            ALUOP_FUNCT: begin
                case (funct)
                    6'b100000: alucont = 3'b010;
                    6'b100010: alucont = 3'b110;
                    6'b100100: alucont = 3'b000;
                    6'b100101: alucont = 3'b001;
                    6'b101010: alucont = 3'b111;
                    default:   alucont = 3'b010;
                endcase
            end
            default: alucont = 3'b010;
        endcase
    end

    // Architectural side effects are gated by reset so that the state held
    // before the reset edge cannot write anything.
    assign pcen     = ~reset & (pcwrite | (branch & zero));
    assign regwrite = ~reset & regwrite_raw;
    assign memwrite = ~reset & memwrite_raw;
    assign irwrite  = reset ? '0 : irwrite_raw;
    assign halt     = ~reset & halt_raw;

endmodule
